// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory init sweep plus cpu/dbg arbiter with range checks
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int DEPTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [63:0] dbg_addr,
  input  logic [63:0] dbg_wdata,
  output logic [63:0] dbg_rdata,
  output logic        dbg_gnt,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_rdata,
  output logic        init_busy,
  output logic        addr_err
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_cpu_grants,
  output logic [31:0] stat_dbg_grants,
  output logic [31:0] stat_stall_cycles,
  output logic [15:0] stat_forced
`endif
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_init_idx;
  logic [3:0]    r_wait_cnt;
  logic          r_addr_err;

  logic          w_force;
  logic          w_we;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic [63:0]   w_rdata;
  logic          w_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
      r_wait_cnt <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr_err <= (cpu_gnt | dbg_gnt) & ~w_in_range;
      if (r_state == S_INIT) begin
        r_init_idx <= r_init_idx + 1'b1;
      end else if (dbg_gnt || !dbg_req) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt < 4'(MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    init_busy   = 1'b0;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    w_force     = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_rdata     = '0;
    w_in_range  = 1'b1;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    cpu_rdata   = '0;
    dbg_rdata   = '0;
    case (r_state)
      S_INIT: begin
        init_busy = 1'b1;
        mem_write = 1'b1;
        mem_addr  = 64'({r_init_idx, 3'b000});
        mem_wdata = 64'(r_init_idx);
        if (r_init_idx == IW'(DEPTH - 1)) w_state_nxt = S_RUN;
      end
      default: begin
        // A dbg port denied MAX_WAIT cycles in a row overrides the cpu once.
        w_force = dbg_req && (r_wait_cnt == 4'(MAX_WAIT));
        if (w_force)      dbg_gnt = 1'b1;
        else if (cpu_req) cpu_gnt = 1'b1;
        else if (dbg_req) dbg_gnt = 1'b1;

        if (cpu_gnt) begin
          w_we    = cpu_we;
          w_addr  = cpu_addr;
          w_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
          w_we    = dbg_we;
          w_addr  = dbg_addr;
          w_wdata = dbg_wdata;
        end
        w_in_range = (w_addr >> (IW + 3)) == 64'd0;

        if (cpu_gnt || dbg_gnt) begin
          mem_addr  = w_addr;
          mem_wdata = w_wdata;
          mem_write = w_we & w_in_range;
          mem_read  = ~w_we;
          if (!w_we && w_in_range) w_rdata = mem_rdata;
        end
        if (cpu_gnt) cpu_rdata = w_rdata;
        if (dbg_gnt) dbg_rdata = w_rdata;
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign addr_err  = r_addr_err;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_cpu;
  logic [31:0] r_stat_dbg;
  logic [31:0] r_stat_stall;
  logic [15:0] r_stat_forced;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_cpu    <= '0;
      r_stat_dbg    <= '0;
      r_stat_stall  <= '0;
      r_stat_forced <= '0;
    end else if (r_state == S_RUN) begin
      if (cpu_gnt && ~&r_stat_cpu)      r_stat_cpu    <= r_stat_cpu + 1'b1;
      if (dbg_gnt && ~&r_stat_dbg)      r_stat_dbg    <= r_stat_dbg + 1'b1;
      if (cpu_stall && ~&r_stat_stall)  r_stat_stall  <= r_stat_stall + 1'b1;
      if (w_force && ~&r_stat_forced)   r_stat_forced <= r_stat_forced + 1'b1;
    end
  end

  assign stat_cpu_grants   = r_stat_cpu;
  assign stat_dbg_grants   = r_stat_dbg;
  assign stat_stall_cycles = r_stat_stall;
  assign stat_forced       = r_stat_forced;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
// Holds the data memory itself and a spec-level reference model.
module tb_dmem_arbiter;
  localparam int DEPTH    = 32;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [63:0] dbg_addr = '0, dbg_wdata = '0;
  logic [63:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_gnt, cpu_stall, dbg_gnt, mem_write, mem_read, init_busy, addr_err;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_gnt(dbg_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .init_busy(init_busy), .addr_err(addr_err)
  );

  // Physical memory: 64 slots on address[8:3], preloaded with junk so the sweep matters.
  logic [63:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = {32'hBADC0DE0, 32'(i)};
  assign mem_rdata = mem[mem_addr[8:3]];
  always @(posedge clk) if (mem_write) mem[mem_addr[8:3]] <= mem_wdata;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  // Reference model state
  logic [63:0] ref_mem [0:DEPTH-1];
  bit m_live = 0, m_init = 1, m_err = 0;
  int m_idx = 0, m_wait = 0;

  always @(negedge clk) begin : model
    int          win;
    bit          we, inr;
    logic [63:0] a, wd, rd;
    win = 0; we = 0; a = '0; wd = '0; rd = '0;
    if (!m_init) begin
      if (dbg_req && m_wait == MAX_WAIT) win = 2;
      else if (cpu_req)                  win = 1;
      else if (dbg_req)                  win = 2;
    end
    if (win == 1) begin we = cpu_we; a = cpu_addr; wd = cpu_wdata; end
    else if (win == 2) begin we = dbg_we; a = dbg_addr; wd = dbg_wdata; end
    inr = a < 64'(DEPTH * 8);
    if (win != 0 && !we && inr) rd = ref_mem[int'(a >> 3)];

    if (m_live) begin
      chk1("init_busy", init_busy, m_init);
      chk1("cpu_gnt", cpu_gnt, win == 1);
      chk1("dbg_gnt", dbg_gnt, win == 2);
      chk1("cpu_stall", cpu_stall, cpu_req && win != 1);
      chk1("addr_err", addr_err, m_err);
      if (m_init) begin
        chk1("mem_write", mem_write, 1'b1);
        chk1("mem_read", mem_read, 1'b0);
        chk("mem_addr", mem_addr, 64'(m_idx * 8));
        chk("mem_wdata", mem_wdata, 64'(m_idx));
      end else begin
        chk1("mem_write", mem_write, win != 0 && we && inr);
        chk1("mem_read", mem_read, win != 0 && !we);
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, wd);
      end
      chk("cpu_rdata", cpu_rdata, (win == 1) ? rd : 64'd0);
      chk("dbg_rdata", dbg_rdata, (win == 2) ? rd : 64'd0);
    end

    if (reset) begin
      m_live = 1; m_init = 1; m_idx = 0; m_wait = 0; m_err = 0;
    end else if (m_live) begin
      if (m_init) begin
        ref_mem[m_idx] = 64'(m_idx);
        m_idx++;
        if (m_idx == DEPTH) m_init = 0;
        m_err = 0;
      end else begin
        if (win != 0 && we && inr) ref_mem[int'(a >> 3)] = wd;
        m_err = (win != 0) && !inr;
        if (dbg_req && win != 2) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        else m_wait = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 64'd1 << $urandom_range(8, 63);
    if (r == 1) return {$urandom, $urandom};
    return 64'($urandom_range(0, 255));
  endfunction

  task automatic sweep_checks();
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk1("lit_sweep_busy_first", init_busy, 1'b1);
        chk("lit_sweep_addr_first", mem_addr, 64'h0);
        chk1("lit_sweep_gnt_first", cpu_gnt | dbg_gnt, 1'b0);
      end
      if (k == 32) begin
        chk("lit_sweep_addr_last", mem_addr, 64'hF8);
        chk("lit_sweep_wdata_last", mem_wdata, 64'd31);
        chk1("lit_sweep_stall_last", cpu_stall, 1'b1);
      end
      if (k == 33) begin
        chk1("lit_run_busy", init_busy, 1'b0);
        chk1("lit_run_cpu_gnt", cpu_gnt, 1'b1);
      end
    end
  endtask

  initial begin
    cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("lit_rst_busy", init_busy, 1'b1);
    chk1("lit_rst_gnt", cpu_gnt, 1'b0);
    chk1("lit_rst_stall", cpu_stall, 1'b1);
    chk1("lit_rst_write", mem_write, 1'b1);
    chk1("lit_rst_read", mem_read, 1'b0);
    chk1("lit_rst_err", addr_err, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    sweep_checks();

    step(); cpu_we = 1'b1; cpu_addr = 64'h40; cpu_wdata = 64'hDEADBEEF;
    @(negedge clk);
    chk1("lit_store_write", mem_write, 1'b1);
    chk1("lit_store_gnt", cpu_gnt, 1'b1);
    step(); cpu_we = 1'b0;
    @(negedge clk);
    chk("lit_load_data", cpu_rdata, 64'hDEADBEEF);
    chk1("lit_load_stall", cpu_stall, 1'b0);

    step(); cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h18;
    @(negedge clk);
    chk1("lit_dbg_gnt", dbg_gnt, 1'b1);
    chk("lit_dbg_rdata", dbg_rdata, 64'd3);
    chk("lit_dbg_cpu_rdata", cpu_rdata, 64'd0);

    step(); cpu_req = 1'b1; cpu_addr = 64'h0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk1("lit_starve_dbg_gnt", dbg_gnt, (i % 5) == 4);
      chk1("lit_starve_stall", cpu_stall, (i % 5) == 4);
    end

    step(); dbg_req = 1'b0; cpu_we = 1'b1; cpu_addr = 64'h100; cpu_wdata = 64'h55;
    @(negedge clk);
    chk1("lit_oor_gnt", cpu_gnt, 1'b1);
    chk1("lit_oor_write", mem_write, 1'b0);
    step(); cpu_we = 1'b0; cpu_addr = 64'h0;
    @(negedge clk);
    chk1("lit_oor_err", addr_err, 1'b1);
    chk("lit_oor_load0", cpu_rdata, 64'd0);
    step(); cpu_addr = 64'h148;
    @(negedge clk);
    chk("lit_oor_read", cpu_rdata, 64'd0);

    repeat (800) begin
      step();
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = $urandom_range(0, 2) == 0;
      cpu_addr  = rand_addr();
      cpu_wdata = {$urandom, $urandom};
      dbg_req   = ($urandom_range(0, 9) < 6);
      dbg_we    = $urandom_range(0, 2) == 0;
      dbg_addr  = rand_addr();
      dbg_wdata = {$urandom, $urandom};
    end

    step(); cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
    cpu_addr = 64'h20; dbg_addr = 64'h28;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    sweep_checks();

    repeat (60) begin
      step();
      cpu_req  = $urandom_range(0, 1) == 1;
      cpu_we   = 1'b0;
      cpu_addr = 64'($urandom_range(0, 255));
      dbg_req  = $urandom_range(0, 1) == 1;
      dbg_addr = 64'($urandom_range(0, 255));
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
